approx_mul_rr_sched: RTL

Round-robin scheduler that shares one approximate 32x32 unsigned multiplier (l10 truncation with three correction terms) among `NREQ` requesters. It accepts operand pairs over valid/ready, issues at most one multiply per cycle into a `PIPE`-stage registered datapath, and returns each product tagged with its requester id through a credit-protected output FIFO. It sits between the fixed-point kernels and the shared arithmetic resource.

---
 rtl/approx_mul_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/approx_mul_rr_sched.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/approx_mul_pkg.sv
// Shared widths, the pipeline entry type and the l10 approximate multiply.
// The multiplier is used by the scheduler datapath.
package approx_mul_pkg;

    localparam int unsigned XW      = 32;
    localparam int unsigned ZW      = 64;
    localparam int unsigned TRUNC   = 10;
    localparam int unsigned IDW_MAX = 3;

    typedef struct packed {
        logic               valid;
        logic [IDW_MAX-1:0] id;
        logic [ZW-1:0]      z;
    } pipe_entry_t;

    // Truncated partial product plus three compensation bits for the dropped low columns.
    function automatic logic [ZW-1:0] approx_mul_l10(input logic [XW-1:0] x,
                                                     input logic [XW-1:0] y);
        logic [XW-TRUNC-1:0]    xh;
        logic [2*XW-TRUNC-1:0]  base;
        logic [ZW-1:0]          c;
        xh    = x[XW-1:TRUNC];
        base  = (2*XW-TRUNC)'(xh) * (2*XW-TRUNC)'(y);
        c     = '0;
        c[1]  = x[0] & y[1] & x[1] & y[0];
        c[3]  = (x[0] & y[2]) ^ (x[1] & y[1]);
        c[14] = x[2] & y[12] & x[3] & y[11];
        return {base, {TRUNC{1'b0}}} + c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr_q) + i) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_d    = PW'((32'(idx) + 1) % N);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/approx_mul_rr_sched.sv
// Shares one approximate multiplier among NREQ requesters: round-robin issue,
// PIPE-deep datapath and a credit-protected show-ahead response FIFO.
module approx_mul_rr_sched
    import approx_mul_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PIPE = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*32-1:0]      req_x,
    input  logic [NREQ*32-1:0]      req_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [63:0]             rsp_z,
    output logic                    busy
);

    localparam int unsigned IDW   = $clog2(NREQ);
    localparam int unsigned DEPTH = PIPE + 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned AW    = $clog2(DEPTH);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            grant_en, accept, pop;
    logic [NREQ-1:0] gnt;

    // Credits are taken from the registered count only, so a pop frees a slot one cycle later.
    assign grant_en = rst_n && (cnt_q < CW'(DEPTH));

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (grant_en),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    logic [IDW-1:0] sel_id;
    logic [XW-1:0]  sel_x, sel_y;

    always_comb begin
        sel_id = '0;
        sel_x  = '0;
        sel_y  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_id = IDW'(i);
                sel_x  = req_x[32*i +: 32];
                sel_y  = req_y[32*i +: 32];
            end
        end
    end

    logic           s0_vld_q, s0_vld_d;
    logic [IDW-1:0] s0_id_q, s0_id_d;
    logic [XW-1:0]  s0_x_q, s0_x_d, s0_y_q, s0_y_d;

    always_comb begin
        s0_vld_d = accept;
        s0_id_d  = sel_id;
        s0_x_d   = sel_x;
        s0_y_d   = sel_y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_vld_q <= 1'b0;
            s0_id_q  <= '0;
            s0_x_q   <= '0;
            s0_y_q   <= '0;
        end else begin
            s0_vld_q <= s0_vld_d;
            s0_id_q  <= s0_id_d;
            s0_x_q   <= s0_x_d;
            s0_y_q   <= s0_y_d;
        end
    end

    pipe_entry_t s0_ent, fifo_in;

    always_comb begin
        s0_ent          = '0;
        s0_ent.valid    = s0_vld_q;
        s0_ent.id[IDW-1:0] = s0_id_q;
        s0_ent.z        = approx_mul_l10(s0_x_q, s0_y_q);
    end

    // The FIFO write is the last of the PIPE stages, so only PIPE-1 product registers exist.
    if (PIPE == 1) begin : g_nopipe
        assign fifo_in = s0_ent;
    end else begin : g_pipe
        pipe_entry_t prod_q [PIPE-1];
        pipe_entry_t prod_d [PIPE-1];

        always_comb begin
            prod_d[0] = s0_ent;
            for (int unsigned k = 1; k < PIPE - 1; k++) begin
                prod_d[k] = prod_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            for (int unsigned k = 0; k < PIPE - 1; k++) begin
                if (!rst_n) begin
                    prod_q[k] <= '0;
                end else begin
                    prod_q[k] <= prod_d[k];
                end
            end
        end

        assign fifo_in = prod_q[PIPE-2];
    end

    logic unused_fifo_id;
    assign unused_fifo_id = ^fifo_in.id;

    logic [IDW-1:0] mem_id_q [DEPTH];
    logic [IDW-1:0] mem_id_d [DEPTH];
    logic [ZW-1:0]  mem_z_q  [DEPTH];
    logic [ZW-1:0]  mem_z_d  [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  fcnt_q, fcnt_d;
    logic           wr;

    assign wr        = fifo_in.valid;
    assign rsp_valid = (fcnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_id    = rsp_valid ? mem_id_q[rd_ptr_q] : '0;
    assign rsp_z     = rsp_valid ? mem_z_q[rd_ptr_q] : '0;

    always_comb begin
        mem_id_d = mem_id_q;
        mem_z_d  = mem_z_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr) begin
            mem_id_d[wr_ptr_q] = fifo_in.id[IDW-1:0];
            mem_z_d[wr_ptr_q]  = fifo_in.z;
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        fcnt_d = fcnt_q + CW'(wr) - CW'(pop);
        cnt_d  = cnt_q + CW'(accept) - CW'(pop);
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        mem_id_q <= mem_id_d;
        mem_z_q  <= mem_z_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule
